// File: rtl/enkel_pkg.sv
// enkel_pkg: shared types and bus constants for the program loader.
// Phase encodings cover the optional LOADER_VERIFY_EN read-back.
package enkel_pkg;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_WAIT,
    LD_CYCLE,
    LD_FIN,
    LD_RUN,
    LD_ERR
  } loader_state_t;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SETUP,
    PH_WRITE,
    PH_HOLD,
    PH_VRD1,
    PH_VRD2
  } sram_phase_t;

  localparam logic CS_N_IDLE = 1'b1;
  localparam logic WE_N_IDLE = 1'b1;
  localparam logic OE_N_IDLE = 1'b1;

endpackage

// File: rtl/sram_cycle_gen.sv
// sram_cycle_gen: one SRAM write (setup/write/hold) per start pulse.
// LOADER_VERIFY_EN appends a two-cycle read-back and compare.
module sram_cycle_gen
  import enkel_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int WE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              cs_n_o,
  output logic              we_n_o,
  output logic              oe_n_o,
  output logic              wdata_oe_o,
  output logic              cycle_done_o,
  output logic              verify_err_o
);

  localparam int TW =
    (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [TW-1:0] WE_LAST =
    TW'(WE_CYCLES - 1);

  sram_phase_t   ph_q, ph_d;
  logic [TW-1:0] tmr_q, tmr_d;

  // Phase sequencing; the timer counts remaining WE-low cycles.
  always_comb begin
    ph_d  = ph_q;
    tmr_d = tmr_q;
    unique case (ph_q)
      PH_IDLE: begin
        if (start_i) ph_d = PH_SETUP;
      end
      PH_SETUP: begin
        ph_d  = PH_WRITE;
        tmr_d = WE_LAST;
      end
      PH_WRITE: begin
        if (tmr_q == '0) ph_d = PH_HOLD;
        else tmr_d = tmr_q - 1'b1;
      end
      PH_HOLD: begin
`ifdef LOADER_VERIFY_EN
        ph_d = PH_VRD1;
`else
        ph_d = PH_IDLE;
`endif
      end
      PH_VRD1: ph_d = PH_VRD2;
      PH_VRD2: ph_d = PH_IDLE;
      default: ph_d = PH_IDLE;
    endcase
  end

  // Phase and timer registers; reset aborts any write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q  <= PH_IDLE;
      tmr_q <= '0;
    end else begin
      ph_q  <= ph_d;
      tmr_q <= tmr_d;
    end
  end

  assign cs_n_o = (ph_q == PH_IDLE) ? CS_N_IDLE : 1'b0;
  assign we_n_o = (ph_q == PH_WRITE) ? 1'b0 : WE_N_IDLE;
  assign wdata_oe_o = (ph_q == PH_SETUP) ||
                      (ph_q == PH_WRITE) ||
                      (ph_q == PH_HOLD);

`ifdef LOADER_VERIFY_EN
  assign oe_n_o = ((ph_q == PH_VRD1) ||
                   (ph_q == PH_VRD2)) ? 1'b0 : OE_N_IDLE;
  assign cycle_done_o = (ph_q == PH_VRD2);
  assign verify_err_o = (ph_q == PH_VRD2) &&
                        (rdata_i != data_i);
`else
  logic unused_rdata;
  assign unused_rdata = ^{rdata_i, data_i};
  assign oe_n_o       = OE_N_IDLE;
  assign cycle_done_o = (ph_q == PH_HOLD);
  assign verify_err_o = 1'b0;
`endif

endmodule

// File: rtl/program_loader.sv
// program_loader: boot stage streaming bytes into SRAM, then run.
// Build option LOADER_VERIFY_EN adds per-byte read-back verify.
module program_loader
  import enkel_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int WE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              master_reset_n,
  input  logic              load_begin,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_cs_n,
  output logic              mem_we_n,
  output logic              mem_oe_n,
  output logic              bus_grant,
  output logic              run_pulse,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  loader_state_t     st_q, st_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;
  logic              cyc_done;
  logic              vfy_err;

  assign byte_ready = (st_q == LD_WAIT);
  assign accept     = byte_valid && byte_ready;

  // Session FSM: accept, run one SRAM cycle, advance or finish.
  always_comb begin
    st_d   = st_q;
    addr_d = addr_q;
    data_d = data_q;
    last_d = last_q;
    done_d = done_q;
    err_d  = err_q;
    unique case (st_q)
      LD_IDLE: begin
        if (load_begin) begin
          st_d   = LD_WAIT;
          addr_d = '0;
          done_d = 1'b0;
          err_d  = 1'b0;
        end
      end
      LD_WAIT: begin
        if (accept) begin
          data_d = byte_data;
          last_d = byte_last;
          st_d   = LD_CYCLE;
        end
      end
      LD_CYCLE: begin
        if (cyc_done) begin
          if (vfy_err) begin
            st_d  = LD_ERR;
            err_d = 1'b1;
          end else if (last_q) begin
            st_d = LD_FIN;
          end else if (addr_q == ADDR_MAX) begin
            st_d  = LD_ERR;
            err_d = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
            st_d   = LD_WAIT;
          end
        end
      end
      LD_FIN: begin
        st_d   = LD_RUN;
        done_d = 1'b1;
      end
      LD_RUN:  st_d = LD_IDLE;
      LD_ERR:  st_d = LD_IDLE;
      default: st_d = LD_IDLE;
    endcase
  end

  // Session registers with immediate asynchronous reset.
  always_ff @(posedge clk or negedge master_reset_n) begin
    if (!master_reset_n) begin
      st_q   <= LD_IDLE;
      addr_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      addr_q <= addr_d;
      data_q <= data_d;
      last_q <= last_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  sram_cycle_gen #(
    .DATA_W    (DATA_W),
    .WE_CYCLES (WE_CYCLES)
  ) u_cyc (
    .clk          (clk),
    .rst_n        (master_reset_n),
    .start_i      (accept),
    .data_i       (data_q),
    .rdata_i      (mem_rdata),
    .cs_n_o       (mem_cs_n),
    .we_n_o       (mem_we_n),
    .oe_n_o       (mem_oe_n),
    .wdata_oe_o   (mem_wdata_oe),
    .cycle_done_o (cyc_done),
    .verify_err_o (vfy_err)
  );

  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;

  // Grant drops in FIN, one cycle ahead of the run pulse.
  assign bus_grant = (st_q == LD_WAIT) ||
                     (st_q == LD_CYCLE);
  assign busy      = bus_grant || (st_q == LD_FIN);
  assign run_pulse = (st_q == LD_RUN);
  assign done      = done_q;
  assign error     = err_q;

endmodule
